// File: rtl/hyperbus_rxbuf.sv
// ---------------------------------------------------------------------------
// hyperbus_rxbuf
//
// HyperBus read-data receive buffer. Once a burst is armed with start_i, the
// block collects DDR-captured beats (one beat = 2*WIDTH bits) that are
// qualified by RWDS == 2'b01. It packs pairs of beats into 4*WIDTH-bit words
// and pushes them into a small first-word-fall-through FIFO. Each FIFO entry
// carries a flag marking the final word of its burst. If the bus goes quiet
// for too long in mid-burst, a watchdog timer moves the block into a sticky
// error state.
//
// Parameters
//   WIDTH    HyperBus DQ width; one beat is 2*WIDTH bits
//   DEPTH    FIFO entry count (power of two, >= 2)
//   TIMEOUT  idle clk90 cycles allowed between valid beats
//
// Ports
//   clk90        sole clock, rising edge
//   rst          asynchronous, active-high reset
//   start_i      one-cycle pulse that arms a burst capture
//   burst_len_i  beats expected in the burst (0 means 16), sampled on start_i
//   cap_dat_i    DDR-captured DQ pair (one beat)
//   cap_rwds_i   DDR-captured RWDS pair; 2'b01 marks a valid beat
//   dat_o        FIFO head word
//   last_o       head word is the final word of its burst
//   valid_o      FIFO is non-empty
//   ready_i      consumer accepts the head word
//   count_o      FIFO occupancy, 0..DEPTH
//   busy_o       a burst capture is in progress
//   done_o       one-cycle pulse after the final beat of a burst
//   timeout_o    sticky watchdog error flag
//   overflow_o   sticky flag: a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module hyperbus_rxbuf #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                       clk90,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [3:0]                 burst_len_i,
    input  logic [2*WIDTH-1:0]         cap_dat_i,
    input  logic [1:0]                 cap_rwds_i,
    output logic [4*WIDTH-1:0]         dat_o,
    output logic                       last_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o,
    output logic                       overflow_o
);

    localparam int BEAT_W  = 2 * WIDTH;
    localparam int WORD_W  = 4 * WIDTH;
    localparam int ENTRY_W = WORD_W + 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ERROR
    } state_t;

    state_t             state;
    logic [4:0]         len_total;
    logic [4:0]         beat_cnt;
    logic [TMR_W-1:0]   timer;

    // The pack register only needs its upper half. An odd-index beat fills
    // the lower half and is pushed on that same edge, so the lower half never
    // has to be held.
    logic [BEAT_W-1:0]  pack_hi;

    logic               beat_valid;
    logic               final_beat;
    logic               push_req;
    logic [WORD_W-1:0]  push_word;
    logic               push_last;
    logic               push_ok;
    logic               drop;
    logic               pop;
    logic               fifo_full;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count_q;
    logic [ENTRY_W-1:0] head;

    // A beat counts only while capturing and only with the rising-then-falling
    // RWDS pattern. Every other RWDS value is bus noise or latency filler.
    assign beat_valid = (state == CAPTURE) && (cap_rwds_i == 2'b01);
    assign final_beat = beat_valid && ((beat_cnt + 5'd1) == len_total);

    // Work out what the current beat pushes. An odd-index beat completes a
    // pair. An even-index beat that is also the last beat of an odd-length
    // burst is pushed at once, padded with zeros in the low half.
    always_comb begin
        push_req  = 1'b0;
        push_word = '0;
        push_last = 1'b0;
        if (beat_valid) begin
            if (beat_cnt[0]) begin
                push_req  = 1'b1;
                push_word = {pack_hi, cap_dat_i};
                push_last = final_beat;
            end else if (final_beat) begin
                push_req  = 1'b1;
                push_word = {cap_dat_i, {BEAT_W{1'b0}}};
                push_last = 1'b1;
            end
        end
    end

    // A full FIFO can still accept a push when the head leaves on the same
    // edge. Any other push to a full FIFO is lost and flagged.
    assign pop       = valid_o && ready_i;
    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && !push_ok;

    // Capture state machine. It holds the burst length, beat counter, pack
    // register and watchdog timer, and registers the status outputs. A start
    // pulse is honoured from IDLE or ERROR only, and it clears the sticky
    // flags for the new burst. The timer reloads on every valid beat. When it
    // reaches zero with no beat present, the burst is abandoned. The partial
    // pack word is never pushed in that case.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_total  <= '0;
            beat_cnt   <= '0;
            timer      <= '0;
            pack_hi    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            done_o <= final_beat;
            case (state)
                IDLE, ERROR: begin
                    if (start_i) begin
                        state      <= CAPTURE;
                        len_total  <= (burst_len_i == 4'd0) ? 5'd16 : {1'b0, burst_len_i};
                        beat_cnt   <= '0;
                        pack_hi    <= '0;
                        timer      <= TMR_W'(TIMEOUT);
                        busy_o     <= 1'b1;
                        timeout_o  <= 1'b0;
                        overflow_o <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (beat_valid) begin
                        beat_cnt <= beat_cnt + 5'd1;
                        timer    <= TMR_W'(TIMEOUT);
                        if (!beat_cnt[0]) begin
                            pack_hi <= cap_dat_i;
                        end
                        if (final_beat) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else if (timer == '0) begin
                        state     <= ERROR;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                    if (drop) begin
                        overflow_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // FIFO bookkeeping. DEPTH is a power of two, so the pointers wrap simply
    // by overflowing. The occupancy holds when a push and a pop happen on the
    // same edge.
    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage. It has no reset: after a reset the occupancy is zero, so
    // stale entries are unreachable, and the outputs below are gated on
    // valid_o.
    always_ff @(posedge clk90) begin
        if (push_ok) begin
            mem[wptr] <= {push_last, push_word};
        end
    end

    // First-word-fall-through head. The outputs are forced to zero while the
    // FIFO is empty, so a reset clears them immediately.
    assign head    = mem[rptr];
    assign valid_o = (count_q != '0);
    assign dat_o   = valid_o ? head[WORD_W-1:0] : '0;
    assign last_o  = valid_o & head[WORD_W];
    assign count_o = count_q;

endmodule

// File: tb/tb_hyperbus_rxbuf.sv
// ---------------------------------------------------------------------------
// tb_hyperbus_rxbuf
//
// Directed self-checking bench for hyperbus_rxbuf at its default parameters
// (WIDTH=8, DEPTH=4, TIMEOUT=31). Inputs change on the falling edge of clk90.
// Outputs are sampled on the falling edge before the inputs are updated.
// ---------------------------------------------------------------------------
module tb_hyperbus_rxbuf;

    logic        clk90;
    logic        rst;
    logic        start_i;
    logic [3:0]  burst_len_i;
    logic [15:0] cap_dat_i;
    logic [1:0]  cap_rwds_i;
    logic [31:0] dat_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  count_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    hyperbus_rxbuf #(
        .WIDTH   (8),
        .DEPTH   (4),
        .TIMEOUT (31)
    ) dut (
        .clk90       (clk90),
        .rst         (rst),
        .start_i     (start_i),
        .burst_len_i (burst_len_i),
        .cap_dat_i   (cap_dat_i),
        .cap_rwds_i  (cap_rwds_i),
        .dat_o       (dat_o),
        .last_o      (last_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .overflow_o  (overflow_o)
    );

    // Free-running clock, 10 time units per period.
    initial clk90 = 1'b0;
    always #5 clk90 = ~clk90;

    // Stops the run if it ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk90);
    endtask

    // Everything reads zero while reset is held and after it is released.
    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; burst_len_i = 4'd0;
        cap_dat_i = 16'h0; cap_rwds_i = 2'b00; ready_i = 1'b0;
        tick(); tick();
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy_o); end
        checks++; if ({last_o, done_o, timeout_o, overflow_o} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0000", {last_o, done_o, timeout_o, overflow_o}); end
        rst = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy got %b expected 0", busy_o); end
    endtask

    // Four back-to-back beats with the consumer always ready.
    task automatic test_basic();
        ready_i = 1'b1;
        start_i = 1'b1; burst_len_i = 4'd4;
        tick();
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b expected 1", busy_o); end
        cap_rwds_i = 2'b01; cap_dat_i = 16'h1122;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_early_push got %b expected 0", valid_o); end
        cap_dat_i = 16'h3344;
        tick();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid1 got %b expected 1", valid_o); end
        checks++; if (dat_o !== 32'h11223344) begin errors++; $display("[TB] FAIL basic_word1 got %h expected 11223344", dat_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_last1 got %b expected 0", last_o); end
        cap_dat_i = 16'h5566;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_popped got %b expected 0", valid_o); end
        cap_dat_i = 16'h7788;
        tick();
        checks++; if (dat_o !== 32'h55667788) begin errors++; $display("[TB] FAIL basic_word2 got %h expected 55667788", dat_o); end
        checks++; if (last_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_last2 got %b expected 1", last_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_done got %b expected 1", done_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end got %b expected 0", busy_o); end
        cap_rwds_i = 2'b00;
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b expected 0", done_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained got %b expected 0", valid_o); end
    endtask

    // Odd-length burst with RWDS gaps between beats.
    task automatic test_gaps();
        logic [1:0]  rw [6] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        logic [15:0] dv [6] = '{16'hAAAA, 16'hDEAD, 16'hBBBB, 16'hBEEF, 16'hDEAD, 16'hCCCC};
        ready_i = 1'b0;
        start_i = 1'b1; burst_len_i = 4'd3;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cap_rwds_i = rw[i]; cap_dat_i = dv[i];
            tick();
        end
        cap_rwds_i = 2'b00;
        checks++; if (count_o !== 3'd2) begin errors++; $display("[TB] FAIL gaps_count got %0d expected 2", count_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL gaps_done got %b expected 1", done_o); end
        checks++; if (dat_o !== 32'hAAAABBBB) begin errors++; $display("[TB] FAIL gaps_word1 got %h expected aaaabbbb", dat_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("[TB] FAIL gaps_last1 got %b expected 0", last_o); end
        ready_i = 1'b1;
        tick();
        checks++; if (dat_o !== 32'hCCCC0000) begin errors++; $display("[TB] FAIL gaps_word2 got %h expected cccc0000", dat_o); end
        checks++; if (last_o !== 1'b1) begin errors++; $display("[TB] FAIL gaps_last2 got %b expected 1", last_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL gaps_done_pulse got %b expected 0", done_o); end
        tick();
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL gaps_drained got %0d expected 0", count_o); end
        ready_i = 1'b0;
    endtask

    // One beat of a two-beat burst, then silence until the watchdog fires.
    task automatic test_timeout();
        logic seen_done = 1'b0;
        ready_i = 1'b0;
        start_i = 1'b1; burst_len_i = 4'd2;
        tick();
        start_i = 1'b0;
        cap_rwds_i = 2'b01; cap_dat_i = 16'h1234;
        tick();
        cap_rwds_i = 2'b00;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (done_o) seen_done = 1'b1;
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_still_busy got %b expected 1", busy_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early got %b expected 0", timeout_o); end
        tick();
        if (done_o) seen_done = 1'b1;
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag got %b expected 1", timeout_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy got %b expected 0", busy_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL timeout_count got %0d expected 0", count_o); end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_done got %b expected 0", seen_done); end
        cap_rwds_i = 2'b01; cap_dat_i = 16'h5678;
        tick();
        cap_rwds_i = 2'b00;
        tick();
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL error_ignores_beat got %0d expected 0", count_o); end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky got %b expected 1", timeout_o); end
    endtask

    // Overfill the FIFO, then push into a full FIFO on the same edge as a pop.
    task automatic test_overflow();
        logic [31:0] exp_dat [4] = '{32'h10021003, 32'h10041005, 32'h10061007, 32'h20002001};
        logic        exp_lst [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        ready_i = 1'b0;
        start_i = 1'b1; burst_len_i = 4'd10;
        tick();
        start_i = 1'b0;
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_timeout_cleared got %b expected 0", timeout_o); end
        for (int i = 0; i < 10; i++) begin
            cap_rwds_i = 2'b01; cap_dat_i = 16'h1000 + 16'(i);
            tick();
            if (i == 7) begin
                checks++; if (count_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_full_count got %0d expected 4", count_o); end
                checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got %b expected 0", overflow_o); end
            end
        end
        cap_rwds_i = 2'b00;
        checks++; if (count_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got %0d expected 4", count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b expected 1", overflow_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done got %b expected 1", done_o); end
        start_i = 1'b1; burst_len_i = 4'd2;
        tick();
        start_i = 1'b0;
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared got %b expected 0", overflow_o); end
        cap_rwds_i = 2'b01; cap_dat_i = 16'h2000;
        tick();
        cap_dat_i = 16'h2001; ready_i = 1'b1;
        tick();
        ready_i = 1'b0; cap_rwds_i = 2'b00;
        checks++; if (count_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_pushpop_count got %0d expected 4", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pushpop_flag got %b expected 0", overflow_o); end
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (dat_o !== exp_dat[k]) begin errors++; $display("[TB] FAIL ovf_drain_dat%0d got %h expected %h", k, dat_o, exp_dat[k]); end
            checks++; if (last_o !== exp_lst[k]) begin errors++; $display("[TB] FAIL ovf_drain_last%0d got %b expected %b", k, last_o, exp_lst[k]); end
            tick();
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained got %b expected 0", valid_o); end
        ready_i = 1'b0;
    endtask

    // Reset in the middle of a burst, then a fresh burst right after release.
    task automatic test_reset_mid();
        ready_i = 1'b0;
        start_i = 1'b1; burst_len_i = 4'd8;
        tick();
        start_i = 1'b0;
        cap_rwds_i = 2'b01; cap_dat_i = 16'h0A0A; tick();
        cap_dat_i = 16'h0B0B; tick();
        cap_dat_i = 16'h0C0C; tick();
        cap_dat_i = 16'h0D0D;
        checks++; if (count_o !== 3'd1) begin errors++; $display("[TB] FAIL rstmid_pre_count got %0d expected 1", count_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count_o !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_count got %0d expected 0", count_o); end
        checks++; if ({valid_o, busy_o, last_o, done_o} !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_flags got %b expected 0000", {valid_o, busy_o, last_o, done_o}); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_dat got %h expected 00000000", dat_o); end
        cap_rwds_i = 2'b00;
        tick();
        rst = 1'b0; start_i = 1'b1; burst_len_i = 4'd2;
        tick();
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_restart got %b expected 1", busy_o); end
        cap_rwds_i = 2'b01; cap_dat_i = 16'h5555; tick();
        cap_dat_i = 16'h6666; tick();
        cap_rwds_i = 2'b00;
        checks++; if (count_o !== 3'd1) begin errors++; $display("[TB] FAIL rstmid_new_count got %0d expected 1", count_o); end
        checks++; if (dat_o !== 32'h55556666) begin errors++; $display("[TB] FAIL rstmid_new_dat got %h expected 55556666", dat_o); end
        checks++; if ({last_o, done_o} !== 2'b11) begin errors++; $display("[TB] FAIL rstmid_new_last_done got %b expected 11", {last_o, done_o}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hyperbus_rxbuf.md
HYPERBUS_RXBUF -- requirements
Module: hyperbus_rxbuf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the HyperBus DQ width; one beat is 2*WIDTH bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the FIFO entry count; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 31, meaning the idle clk90 cycles allowed between valid beats before an error.
REQ-004 The block SHALL have port clk90, input, 1 bit: the sole clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port start_i, input, 1 bit: single-cycle pulse that arms a read burst capture.
REQ-007 The block SHALL have port burst_len_i, input, 4 bits: number of beats expected, sampled on start_i; 0 means 16.
REQ-008 The block SHALL have port cap_dat_i, input, 2*WIDTH bits: DDR-captured DQ pair.
REQ-009 The block SHALL have port cap_rwds_i, input, 2 bits: DDR-captured RWDS pair.
REQ-010 The block SHALL have port dat_o, output, 4*WIDTH bits: FIFO head word.
REQ-011 The block SHALL have port last_o, output, 1 bit: the head word is the final word of its burst.
REQ-012 The block SHALL have port valid_o, output, 1 bit: the FIFO is non-empty.
REQ-013 The block SHALL have port ready_i, input, 1 bit: consumer accepts the head word.
REQ-014 The block SHALL have port count_o, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-015 The block SHALL have port busy_o, output, 1 bit: state is CAPTURE.
REQ-016 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when the burst completes.
REQ-017 The block SHALL have port timeout_o, output, 1 bit: sticky timeout error flag.
REQ-018 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when a word was dropped because the FIFO was full.

Function
REQ-019 The block SHALL implement states IDLE, CAPTURE and ERROR.
REQ-020 IDLE or ERROR with start_i=1 SHALL transition to CAPTURE with these actions: latch burst_len_i, clear the beat counter, pack register, timeout_o and overflow_o, and load the timer with TIMEOUT.
REQ-021 start_i SHALL be ignored while in CAPTURE.
REQ-022 A valid beat SHALL be CAPTURE with cap_rwds_i==2'b01.
REQ-023 All other RWDS values SHALL be ignored as data.
REQ-024 Each valid beat SHALL increment the beat counter and reload the timer to TIMEOUT.
REQ-025 Packing SHALL place an even-index beat (0,2,...) in pack[4W-1:2W] and an odd-index beat in pack[2W-1:0], then push {pack, last} into the FIFO.
REQ-026 On the final beat with an odd burst length, the block SHALL push {beat, 2W zeros} immediately.
REQ-027 last SHALL be 1 only for the entry containing the final beat.
REQ-028 Push SHALL occur on the same edge as the completing beat, so the word is visible on dat_o/valid_o one cycle after its beat.
REQ-029 Final beat SHALL cause the following on that edge: state goes to IDLE, and done_o=1 for exactly one cycle on the next cycle.
REQ-030 In CAPTURE with no valid beat, the timer SHALL decrement each cycle.
REQ-031 When the timer is 0 and no valid beat is present, the block SHALL go to ERROR and set timeout_o=1.
REQ-032 The block SHALL NOT push a partial pack word on timeout.
REQ-033 ERROR SHALL be left only via start_i.
REQ-034 The FIFO SHALL be first-word-fall-through: dat_o/last_o show the head whenever valid_o=1, and dat_o/last_o are don't-care when empty.
REQ-035 A pop SHALL occur when valid_o and ready_i are both 1.
REQ-036 A push to a full FIFO SHALL succeed if a pop occurs on the same edge; otherwise the word is dropped and overflow_o is set.
REQ-037 A simultaneous push and pop SHALL leave count_o unchanged.
REQ-038 Read and write pointers SHALL wrap modulo DEPTH.
REQ-039 count_o SHALL range 0..DEPTH.
REQ-040 The FIFO SHALL NOT be flushed by start_i; entries drain only via pop.

Reset
REQ-041 Assertion of rst SHALL asynchronously force: state IDLE, FIFO empty (pointers 0, count_o=0, valid_o=0), and last_o, busy_o, done_o, timeout_o, overflow_o all 0.
REQ-042 Assertion of rst SHALL also asynchronously zero the timer, the beat counter and the pack register.
REQ-043 Reset mid-burst SHALL discard all captured and partial data with no done_o pulse.
REQ-044 The first start_i SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-045 The bench SHALL cover: WIDTH=8, start with burst_len=4, beats 16'h1122, 16'h3344, 16'h5566, 16'h7788 on consecutive cycles with ready_i=1 -> pops 32'h11223344 (last=0) then 32'h55667788 (last=1), one done_o pulse, busy_o=0 afterwards.
REQ-046 The bench SHALL cover: burst_len=3, beats 16'hAAAA, 16'hBBBB, 16'hCCCC interleaved with cap_rwds_i=2'b00 gaps -> words 32'hAAAABBBB (last=0) and 32'hCCCC0000 (last=1).
REQ-047 The bench SHALL cover: burst_len=2, one beat then no beats for TIMEOUT+1 cycles -> ERROR, timeout_o=1, count_o=0, no done_o.
REQ-048 The bench SHALL cover: DEPTH=4, ready_i=0, burst_len=10 -> count_o=4 after 8 beats, 5th word dropped, overflow_o=1; then ready_i=1 on the cycle of a further push to a full FIFO -> push accepted, count_o stays 4.
REQ-049 The bench SHALL cover: rst asserted mid-burst after 3 beats -> all outputs 0 immediately; a new start then captures normally.
